// File: rtl/fpu_result_wb_if.sv
// Valid/ready result stream carrying a packed FP result, its IEEE flags and its precision.
interface fpu_result_wb_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned FLAGW = 5
);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] fp;
   logic [FLAGW-1:0] flags;
   logic             db;

   modport master (output valid, fp, flags, db, input ready);
   modport slave  (input valid, fp, flags, db, output ready);
endinterface

// File: rtl/fpu_result_wb.sv
// FP writeback stage: result FIFO, sticky IEEE status register and precise trap on commit.
module fpu_result_wb #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned FLAGW = 5,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   fpu_result_wb_if.slave   in_bus,
   fpu_result_wb_if.master  out_bus,
   input  logic [FLAGW-1:0] trap_en,
   input  logic             fsr_clr,
   input  logic             fsr_wr,
   input  logic [FLAGW-1:0] fsr_wdata,
   output logic [FLAGW-1:0] fsr,
   output logic             trap,
   output logic [FLAGW-1:0] trap_cause,
   input  logic             trap_ack
);
   localparam int unsigned PTRW = $clog2(DEPTH);
   localparam int unsigned CNTW = $clog2(DEPTH) + 1;

   typedef enum logic {RUN, TRAP} state_t;

   state_t            state;
   logic [PTRW-1:0]   wr_ptr;
   logic [PTRW-1:0]   rd_ptr;
   logic [CNTW-1:0]   count;
   logic [WIDTH-1:0]  fp_mem   [DEPTH];
   logic [FLAGW-1:0]  flag_mem [DEPTH];
   logic              db_mem   [DEPTH];

   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              trap_hit;
   logic [FLAGW-1:0]  commit_flags;
   logic [FLAGW-1:0]  fsr_base;

   assign full  = (count == CNTW'(DEPTH));
   assign empty = (count == CNTW'(0));

   assign in_bus.ready  = !full && (state == RUN);
   assign out_bus.valid = !empty && (state == RUN);
   assign out_bus.fp    = empty ? '0 : fp_mem[rd_ptr];
   assign out_bus.flags = empty ? '0 : flag_mem[rd_ptr];
   assign out_bus.db    = empty ? 1'b0 : db_mem[rd_ptr];

   assign push     = in_bus.valid && in_bus.ready;
   assign pop      = out_bus.valid && out_bus.ready;
   assign trap_hit = pop && (|(out_bus.flags & trap_en));

   // Committed flags are OR'd in after clear/write so a same-cycle commit is never lost.
   assign commit_flags = pop ? out_bus.flags : '0;
   assign fsr_base     = fsr_clr ? '0 : (fsr_wr ? fsr_wdata : fsr);

   // Entry storage needs no reset; the empty mux hides stale contents.
   always_ff @(posedge clk) begin
      if (push) begin
         fp_mem[wr_ptr]   <= in_bus.fp;
         flag_mem[wr_ptr] <= in_bus.flags;
         db_mem[wr_ptr]   <= in_bus.db;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         fsr        <= '0;
         trap       <= 1'b0;
         trap_cause <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTRW'(1);
         if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
         case ({push, pop})
            2'b10:   count <= count + CNTW'(1);
            2'b01:   count <= count - CNTW'(1);
            default: count <= count;
         endcase

         fsr <= fsr_base | commit_flags;

         case (state)
            RUN: begin
               if (trap_hit) begin
                  state      <= TRAP;
                  trap       <= 1'b1;
                  trap_cause <= out_bus.flags & trap_en;
               end
            end
            TRAP: begin
               if (trap_ack) begin
                  state <= RUN;
                  trap  <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_fpu_result_wb.sv
// Directed bench for fpu_result_wb: reset, commit, fill/backpressure, trap, FSR races, wrap, mid-run reset.
module tb_fpu_result_wb;
   localparam int unsigned WIDTH = 64;
   localparam int unsigned FLAGW = 5;
   localparam int unsigned DEPTH = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [FLAGW-1:0] trap_en;
   logic             fsr_clr;
   logic             fsr_wr;
   logic [FLAGW-1:0] fsr_wdata;
   logic [FLAGW-1:0] fsr;
   logic             trap;
   logic [FLAGW-1:0] trap_cause;
   logic             trap_ack;

   int tests  = 0;
   int failed = 0;

   fpu_result_wb_if #(.WIDTH(WIDTH), .FLAGW(FLAGW)) in_bus ();
   fpu_result_wb_if #(.WIDTH(WIDTH), .FLAGW(FLAGW)) out_bus ();

   fpu_result_wb #(.WIDTH(WIDTH), .FLAGW(FLAGW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_bus     (in_bus.slave),
      .out_bus    (out_bus.master),
      .trap_en    (trap_en),
      .fsr_clr    (fsr_clr),
      .fsr_wr     (fsr_wr),
      .fsr_wdata  (fsr_wdata),
      .fsr        (fsr),
      .trap       (trap),
      .trap_cause (trap_cause),
      .trap_ack   (trap_ack)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle before checking or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_in(input logic v, input logic [63:0] fp, input logic [4:0] fl, input logic db);
      in_bus.valid = v;
      in_bus.fp    = fp;
      in_bus.flags = fl;
      in_bus.db    = db;
   endtask

   initial begin
      rst = 1'b1; trap_en = '0; fsr_clr = 1'b0; fsr_wr = 1'b0; fsr_wdata = '0; trap_ack = 1'b0;
      drive_in(1'b0, 64'h0, 5'b0, 1'b0);
      out_bus.ready = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      check("rst_in_ready",  64'(in_bus.ready),  64'd1);
      check("rst_out_valid", 64'(out_bus.valid), 64'd0);
      check("rst_fsr",       64'(fsr),           64'd0);
      check("rst_trap",      64'(trap),          64'd0);
      check("rst_fp_out",    out_bus.fp,         64'd0);

      // Single commit
      out_bus.ready = 1'b1;
      drive_in(1'b1, 64'h3FF0000000000000, 5'b00001, 1'b1);
      tick();
      drive_in(1'b0, 64'h0, 5'b0, 1'b0);
      check("one_valid",  64'(out_bus.valid), 64'd1);
      check("one_fp",     out_bus.fp,         64'h3FF0000000000000);
      check("one_flags",  64'(out_bus.flags), 64'd1);
      check("one_db",     64'(out_bus.db),    64'd1);
      tick();
      check("one_empty",  64'(out_bus.valid), 64'd0);
      check("one_fsr",    64'(fsr),           64'b00001);

      // Fill to DEPTH, third offer refused, drain in order
      fsr_clr = 1'b1; tick(); fsr_clr = 1'b0;
      check("clr_fsr", 64'(fsr), 64'd0);
      out_bus.ready = 1'b0;
      drive_in(1'b1, 64'hAAAA, 5'b00010, 1'b0); tick();
      drive_in(1'b1, 64'hBBBB, 5'b01000, 1'b1); tick();
      check("full_in_ready", 64'(in_bus.ready), 64'd0);
      check("full_head",     out_bus.fp,        64'hAAAA);
      drive_in(1'b1, 64'hCCCC, 5'b00100, 1'b0); tick();
      check("full_refuse_ready", 64'(in_bus.ready), 64'd0);
      check("full_refuse_head",  out_bus.fp,        64'hAAAA);
      drive_in(1'b0, 64'h0, 5'b0, 1'b0);
      out_bus.ready = 1'b1;
      tick();
      check("drain_b_fp",    out_bus.fp,         64'hBBBB);
      check("drain_b_flags", 64'(out_bus.flags), 64'b01000);
      check("drain_b_db",    64'(out_bus.db),    64'd1);
      tick();
      check("drain_empty", 64'(out_bus.valid), 64'd0);
      check("drain_fsr",   64'(fsr),           64'b01010);

      // Trap with an entry queued behind the trapping result
      out_bus.ready = 1'b0;
      trap_en = 5'b10000;
      drive_in(1'b1, 64'h7FF8000000000000, 5'b10000, 1'b1); tick();
      drive_in(1'b1, 64'hC0C0, 5'b00000, 1'b0); tick();
      drive_in(1'b0, 64'h0, 5'b0, 1'b0);
      check("trap_head", out_bus.fp, 64'h7FF8000000000000);
      out_bus.ready = 1'b1;
      tick();
      check("trap_set",       64'(trap),          64'd1);
      check("trap_cause",     64'(trap_cause),    64'b10000);
      check("trap_out_valid", 64'(out_bus.valid), 64'd0);
      check("trap_in_ready",  64'(in_bus.ready),  64'd0);
      check("trap_fsr",       64'(fsr),           64'b11010);
      fsr_clr = 1'b1; tick(); fsr_clr = 1'b0;
      check("trap_hold",       64'(trap),          64'd1);
      check("trap_hold_cause", 64'(trap_cause),    64'b10000);
      check("trap_hold_valid", 64'(out_bus.valid), 64'd0);
      check("trap_fsr_clr",    64'(fsr),           64'd0);
      trap_ack = 1'b1; tick(); trap_ack = 1'b0;
      check("resume_trap",  64'(trap),          64'd0);
      check("resume_valid", 64'(out_bus.valid), 64'd1);
      check("resume_fp",    out_bus.fp,         64'hC0C0);
      tick();
      check("resume_empty", 64'(out_bus.valid), 64'd0);
      check("resume_trap2", 64'(trap),          64'd0);
      trap_en = '0;

      // FSR races against same-cycle commits
      fsr_wr = 1'b1; fsr_wdata = 5'b00011; tick(); fsr_wr = 1'b0;
      check("fsr_wr", 64'(fsr), 64'b00011);
      drive_in(1'b1, 64'hD, 5'b00100, 1'b0); tick();
      drive_in(1'b0, 64'h0, 5'b0, 1'b0);
      fsr_clr = 1'b1; tick(); fsr_clr = 1'b0;
      check("race_clr", 64'(fsr), 64'b00100);
      drive_in(1'b1, 64'hE, 5'b00001, 1'b0); tick();
      drive_in(1'b0, 64'h0, 5'b0, 1'b0);
      fsr_wr = 1'b1; fsr_wdata = 5'b01000; tick(); fsr_wr = 1'b0;
      check("race_wr", 64'(fsr), 64'b01001);
      fsr_clr = 1'b1; fsr_wr = 1'b1; fsr_wdata = 5'b11111; tick();
      fsr_clr = 1'b0; fsr_wr = 1'b0;
      check("clr_over_wr", 64'(fsr), 64'd0);

      // Back-to-back streaming through wrapping pointers
      for (int i = 1; i <= 10; i++) begin
         drive_in(1'b1, 64'(i), 5'b0, 1'b0);
         tick();
         check("wrap_valid", 64'(out_bus.valid), 64'd1);
         check("wrap_ready", 64'(in_bus.ready),  64'd1);
         check("wrap_fp",    out_bus.fp,         64'(i));
      end
      drive_in(1'b0, 64'h0, 5'b0, 1'b0);
      tick();
      check("wrap_empty", 64'(out_bus.valid), 64'd0);

      // Reset mid-operation discards buffered entries and a pending trap
      out_bus.ready = 1'b0;
      trap_en = 5'b00001;
      drive_in(1'b1, 64'h1234, 5'b00001, 1'b0); tick();
      drive_in(1'b0, 64'h0, 5'b0, 1'b0);
      out_bus.ready = 1'b1; tick();
      check("pre_rst_trap", 64'(trap), 64'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("mid_rst_trap",  64'(trap),          64'd0);
      check("mid_rst_valid", 64'(out_bus.valid), 64'd0);
      check("mid_rst_ready", 64'(in_bus.ready),  64'd1);
      check("mid_rst_fsr",   64'(fsr),           64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
